// File: rtl/mod_arith_pkg.sv
// mod_arith_pkg: controller states and constants shared by the modular arithmetic blocks
package mod_arith_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_REARM} state_t;
  localparam int N_DEFAULT = 256;
  localparam logic [255:0] P256K = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
endpackage

// File: rtl/mod_cond_sub.sv
// mod_cond_sub: (N+1)-bit conditional subtract, x >= p ? x - p : x
module mod_cond_sub #(
  parameter int N = 256
) (
  input  logic [N:0]   i_x,
  input  logic [N-1:0] i_p,
  output logic [N:0]   o_y
);
  logic [N:0] w_p;
  assign w_p = {1'b0, i_p};
  assign o_y = (i_x >= w_p) ? i_x - w_p : i_x;
endmodule

// File: rtl/mod_mul.sv
// mod_mul: bit-serial interleaved modular multiplier, result = a*b mod P, MSB of b first
module mod_mul
  import mod_arith_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_mul,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] P,
  output logic         done_mul,
  output logic [N-1:0] result
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  state_t        r_state;
  logic [N-1:0]  r_a, r_b, r_p, r_res;
  logic [N:0]    r_acc;
  logic [IW-1:0] r_i;
  logic          r_done;
  logic [N:0]    w_dbl, w_red1, w_add, w_red2;
  assign w_dbl = r_acc << 1;
  mod_cond_sub #(.N(N)) u_sub_dbl (.i_x(w_dbl), .i_p(r_p), .o_y(w_red1));
  assign w_add = w_red1 + (r_b[r_i] ? {1'b0, r_a} : '0);
  mod_cond_sub #(.N(N)) u_sub_add (.i_x(w_add), .i_p(r_p), .o_y(w_red2));
  // controller and step datapath: capture, N reduce-and-add steps, publish, wait for start release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_acc   <= '0;
      r_i     <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: if (start_mul) begin
          r_a     <= a;
          r_b     <= b;
          r_p     <= P;
          r_acc   <= '0;
          r_i     <= IW'(N - 1);
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_acc <= w_red2;
          r_i   <= r_i - 1'b1;
          if (r_i == '0) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_res   <= r_acc[N-1:0];
          r_done  <= 1'b1;
          r_state <= ST_REARM;
        end
        ST_REARM: if (!start_mul) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign done_mul = r_done;
  assign result   = r_res;
endmodule
